// File: rtl/arcade_input_pkg.sv
// Shared constants, PS/2 key maps and types for the arcade player-input front end.
package arcade_input_pkg;

  localparam int unsigned BTN_W     = 8;
  localparam int unsigned BTN_R     = 0;
  localparam int unsigned BTN_L     = 1;
  localparam int unsigned BTN_D     = 2;
  localparam int unsigned BTN_U     = 3;
  localparam int unsigned BTN_FIRE1 = 4;
  localparam int unsigned BTN_FIRE2 = 5;
  localparam int unsigned BTN_START = 6;
  localparam int unsigned BTN_COIN  = 7;

  // Extended scancodes: bit 8 set means an E0-prefixed key
  localparam logic [8:0] SC_P0_R      = 9'h174;
  localparam logic [8:0] SC_P0_L      = 9'h16B;
  localparam logic [8:0] SC_P0_D      = 9'h172;
  localparam logic [8:0] SC_P0_U      = 9'h175;
  localparam logic [8:0] SC_P0_FIRE1A = 9'h014;
  localparam logic [8:0] SC_P0_FIRE1B = 9'h029;
  localparam logic [8:0] SC_P0_FIRE2  = 9'h011;
  localparam logic [8:0] SC_P0_START  = 9'h016;
  localparam logic [8:0] SC_P0_COIN   = 9'h02E;
  localparam logic [8:0] SC_P1_R      = 9'h02B;
  localparam logic [8:0] SC_P1_L      = 9'h023;
  localparam logic [8:0] SC_P1_D      = 9'h02D;
  localparam logic [8:0] SC_P1_U      = 9'h034;
  localparam logic [8:0] SC_P1_FIRE1  = 9'h01C;
  localparam logic [8:0] SC_P1_FIRE2  = 9'h01B;
  localparam logic [8:0] SC_P1_START  = 9'h01E;
  localparam logic [8:0] SC_P1_COIN   = 9'h036;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] player;
    logic [2:0] idx;
  } key_hit_t;

  function automatic key_hit_t key_decode(input logic [8:0] code);
    key_hit_t k;
    k     = '0;
    k.hit = 1'b1;
    case (code)
      SC_P0_R:      k.idx = 3'(BTN_R);
      SC_P0_L:      k.idx = 3'(BTN_L);
      SC_P0_D:      k.idx = 3'(BTN_D);
      SC_P0_U:      k.idx = 3'(BTN_U);
      SC_P0_FIRE1A: k.idx = 3'(BTN_FIRE1);
      SC_P0_FIRE1B: k.idx = 3'(BTN_FIRE1);
      SC_P0_FIRE2:  k.idx = 3'(BTN_FIRE2);
      SC_P0_START:  k.idx = 3'(BTN_START);
      SC_P0_COIN:   k.idx = 3'(BTN_COIN);
      SC_P1_R:      begin k.player = 2'd1; k.idx = 3'(BTN_R);     end
      SC_P1_L:      begin k.player = 2'd1; k.idx = 3'(BTN_L);     end
      SC_P1_D:      begin k.player = 2'd1; k.idx = 3'(BTN_D);     end
      SC_P1_U:      begin k.player = 2'd1; k.idx = 3'(BTN_U);     end
      SC_P1_FIRE1:  begin k.player = 2'd1; k.idx = 3'(BTN_FIRE1); end
      SC_P1_FIRE2:  begin k.player = 2'd1; k.idx = 3'(BTN_FIRE2); end
      SC_P1_START:  begin k.player = 2'd1; k.idx = 3'(BTN_START); end
      SC_P1_COIN:   begin k.player = 2'd1; k.idx = 3'(BTN_COIN);  end
      default:      k.hit = 1'b0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/coin_shaper.sv
// Per-player coin shaper: edge detect, saturating credit queue and a
// PULSE/GAP sequencer sharing one down-counter.
module coin_shaper
  import arcade_input_pkg::*;
#(
  parameter logic [15:0] PULSE_CYC = 16'd4,
  parameter logic [15:0] GAP_CYC   = 16'd3,
  parameter logic [2:0]  Q_MAX     = 3'd3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic coin_raw_i,
  output logic coin_active_o
);

  coin_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  pend_q, pend_d;
  logic        coin_q;
  logic        edge_c, take_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pend_q        <= '0;
      coin_q        <= 1'b0;
      coin_active_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      coin_q        <= coin_raw_i;
      coin_active_o <= (state_d == PULSE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take_c  = 1'b0;
    edge_c  = coin_raw_i & ~coin_q;
    pend_d  = pend_q;

    unique case (state_q)
      IDLE: begin
        if (pend_q != 3'd0) begin
          state_d = PULSE;
          cnt_d   = PULSE_CYC - 16'd1;
          take_c  = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == 16'd0) begin
          state_d = GAP;
          cnt_d   = GAP_CYC - 16'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == 16'd0) state_d = IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase

    // A simultaneous new credit and dequeue cancel out
    if (edge_c && !take_c) begin
      if (pend_q < Q_MAX) pend_d = pend_q + 3'd1;
    end else if (!edge_c && take_c) begin
      pend_d = pend_q - 3'd1;
    end
  end

endmodule

// File: rtl/arcade_input_map.sv
// Arcade player-input front end: PS/2 key decode, USB/DB pad merge, coin shaping.
// Optional autofire on fire1 is built when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_map
  import arcade_input_pkg::*;
#(
  parameter int unsigned NPLAYERS   = 2,
  parameter logic [15:0] COIN_PULSE = 16'd60000,
  parameter logic [15:0] COIN_GAP   = 16'd60000,
  parameter logic [2:0]  COIN_QMAX  = 3'd3,
  parameter logic [19:0] AF_HALF    = 20'd300000
) (
  input  logic                  clk_sys,
  input  logic                  Reset_I,
  input  logic [10:0]           ps2_key,
  input  logic [NPLAYERS*8-1:0] joy_usb,
  input  logic [NPLAYERS*8-1:0] joy_db,
  input  logic [NPLAYERS-1:0]   db_ena,
  input  logic [NPLAYERS-1:0]   af_ena,
  output logic [NPLAYERS*8-1:0] ply_n
);

  localparam int unsigned PW = BTN_W;

  logic                          tog_q;
  logic [NPLAYERS-1:0][PW-1:0]   key_q, key_d;
  logic [NPLAYERS-1:0][PW-1:0]   usb_c, db_c, raw_c;
  logic [NPLAYERS-1:0][6:0]      out_q, out_d;
  logic [NPLAYERS-1:0]           fire_c, coin_act;
  logic [PW-1:0]                 pad_c;
  int unsigned                   n_db_c;
  key_hit_t                      hit_c;

  assign usb_c = joy_usb;
  assign db_c  = joy_db;

  // A change of ps2_key[10] marks a new key event
  always_comb begin
    key_d = key_q;
    hit_c = key_decode(ps2_key[8:0]);
    if ((ps2_key[10] != tog_q) && hit_c.hit) begin
      for (int unsigned p = 0; p < NPLAYERS; p++) begin
        if (hit_c.player == 2'(p)) key_d[p][hit_c.idx] = ps2_key[9];
      end
    end
  end

  // USB pads shift down past players that are taken by a DB pad
  always_comb begin
    raw_c  = '0;
    pad_c  = '0;
    n_db_c = 0;
    for (int unsigned p = 0; p < NPLAYERS; p++) begin
      n_db_c = 0;
      for (int unsigned q = 0; q < p; q++) n_db_c = n_db_c + 32'(db_ena[q]);
      pad_c = '0;
      if (db_ena[p]) begin
        pad_c = db_c[p];
      end else begin
        for (int unsigned u = 0; u < NPLAYERS; u++) begin
          if (u + n_db_c == p) pad_c = usb_c[u];
        end
      end
      raw_c[p] = pad_c | key_q[p];
    end
  end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  logic [NPLAYERS-1:0][19:0] af_cnt_q, af_cnt_d;
  logic [NPLAYERS-1:0]       af_ph_q, af_ph_d;

  always_comb begin
    af_cnt_d = af_cnt_q;
    af_ph_d  = af_ph_q;
    fire_c   = '0;
    for (int unsigned p = 0; p < NPLAYERS; p++) begin
      if (af_ena[p] && raw_c[p][BTN_FIRE1]) begin
        if (af_cnt_q[p] == AF_HALF - 20'd1) begin
          af_cnt_d[p] = '0;
          af_ph_d[p]  = ~af_ph_q[p];
        end else begin
          af_cnt_d[p] = af_cnt_q[p] + 20'd1;
        end
      end else begin
        af_cnt_d[p] = '0;
        af_ph_d[p]  = 1'b1;
      end
      fire_c[p] = raw_c[p][BTN_FIRE1] & af_ph_q[p];
    end
  end

  always_ff @(posedge clk_sys or negedge Reset_I) begin
    if (!Reset_I) begin
      af_cnt_q <= '0;
      af_ph_q  <= '1;
    end else begin
      af_cnt_q <= af_cnt_d;
      af_ph_q  <= af_ph_d;
    end
  end
`else
  logic unused_af_c;
  assign unused_af_c = ^{af_ena, AF_HALF};

  always_comb begin
    fire_c = '0;
    for (int unsigned p = 0; p < NPLAYERS; p++) fire_c[p] = raw_c[p][BTN_FIRE1];
  end
`endif

  always_comb begin
    out_d = out_q;
    for (int unsigned p = 0; p < NPLAYERS; p++) begin
      out_d[p] = ~{raw_c[p][BTN_START], raw_c[p][BTN_FIRE2], fire_c[p], raw_c[p][BTN_U:BTN_R]};
    end
  end

  always_ff @(posedge clk_sys or negedge Reset_I) begin
    if (!Reset_I) begin
      tog_q <= 1'b0;
      key_q <= '0;
      out_q <= '1;
    end else begin
      tog_q <= ps2_key[10];
      key_q <= key_d;
      out_q <= out_d;
    end
  end

  for (genvar p = 0; p < NPLAYERS; p++) begin : g_ply
    coin_shaper #(
      .PULSE_CYC (COIN_PULSE),
      .GAP_CYC   (COIN_GAP),
      .Q_MAX     (COIN_QMAX)
    ) u_coin (
      .clk_i         (clk_sys),
      .rst_ni        (Reset_I),
      .coin_raw_i    (raw_c[p][BTN_COIN]),
      .coin_active_o (coin_act[p])
    );
    assign ply_n[p*PW +: PW] = {~coin_act[p], out_q[p]};
  end

endmodule
